// File: rtl/rv32m_pkg.sv
// Shared types and constants for the RV32M front-end sequencer.
// Operation codes are the funct3 field of the OP (M-extension) instruction.
package rv32m_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } rv32m_op_t;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_WAIT_MUL = 3'd1,
        SEQ_WAIT_DIV = 3'd2,
        SEQ_FIXUP    = 3'd3,
        SEQ_DONE     = 3'd4
    } rv32m_seq_state_t;

    localparam logic [31:0] RV32M_DIV0_QUOT = 32'hFFFFFFFF;
    localparam logic [31:0] RV32M_INT_MIN   = 32'h80000000;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/rv32m_result_fixup.sv
// Combinational sign correction and result select for the sequencer's FIXUP state.
// The units work on unsigned magnitudes; this block restores the signs and
// picks the low/high product word or the quotient/remainder.
module rv32m_result_fixup
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  rv32m_op_t         op,
    input  logic              sa,
    input  logic              sb,
    input  logic [2*XLEN-1:0] product,
    input  logic [XLEN-1:0]   quotient,
    input  logic [XLEN-1:0]   remainder,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // Negate by operand signs, then select the architectural result word.
    always_comb begin
        prod_fix = (sa ^ sb) ? -product : product;
        // Quotient sign follows both operands; remainder sign follows the dividend.
        quot_fix = (sa ^ sb) ? -quotient : quotient;
        rem_fix  = sa ? -remainder : remainder;
        result   = '0;
        if (is_div(op)) begin
            result = op[1] ? rem_fix : quot_fix;
        end else if (op == OP_MUL) begin
            result = prod_fix[XLEN-1:0];
        end else begin
            result = prod_fix[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/rv32m_sequencer.sv
// RV32M front-end sequencer: accepts one M-extension op, resolves divide-by-zero
// and signed overflow locally, drives the shared iterative mul/div units with
// unsigned magnitudes, then applies sign and hi/lo fix-up.
// Optional build macro RV32M_SEQ_RESULT_CACHE_EN keeps the last divider result
// so a matching DIV/REM pair (e.g. quotient then remainder) skips the divider.
module rv32m_sequencer
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic              mul_start,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic              mul_done,
    input  logic [2*XLEN-1:0] mul_product,
    output logic              div_start,
    output logic [XLEN-1:0]   div_dividend,
    output logic [XLEN-1:0]   div_divisor,
    input  logic              div_done,
    input  logic [XLEN-1:0]   div_quotient,
    input  logic [XLEN-1:0]   div_remainder,
    output logic              unit_flush
);

    rv32m_seq_state_t  state_q, state_d;
    rv32m_op_t         op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              mul_start_q, mul_start_d;
    logic              div_start_q, div_start_d;
    logic              unit_flush_q, unit_flush_d;

    rv32m_op_t         op_in;
    logic              sa_in, sb_in;
    logic              div0, ovf, special;
    logic [XLEN-1:0]   special_res;
    logic              accept;
    logic              cache_hit;
    logic [XLEN-1:0]   fix_result;

`ifdef RV32M_SEQ_RESULT_CACHE_EN
    logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0]   tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic              tag_s_q, tag_s_d;
    logic              cache_v_q, cache_v_d;
`endif

    rv32m_result_fixup #(.XLEN(XLEN)) u_fixup (
        .op        (op_q),
        .sa        (sa_q),
        .sb        (sb_q),
        .product   (prod_q),
        .quotient  (quot_q),
        .remainder (rem_q),
        .result    (fix_result)
    );

    // Decode the incoming request: sign flags, special cases and cache lookup.
    always_comb begin
        op_in  = rv32m_op_t'(op);
        sa_in  = rs1_data[XLEN-1] & ((op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                                     (op_in == OP_DIV)  || (op_in == OP_REM));
        sb_in  = rs2_data[XLEN-1] & ((op_in == OP_MULH) || (op_in == OP_DIV) ||
                                     (op_in == OP_REM));
        div0   = is_div(op) && (rs2_data == '0);
        ovf    = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                 (rs1_data == RV32M_INT_MIN) && (rs2_data == '1);
        special = div0 || ovf;
        // Divide-by-zero takes priority; the two cases never overlap anyway.
        if (div0) begin
            special_res = op[1] ? rs1_data : RV32M_DIV0_QUOT;
        end else begin
            special_res = op[1] ? '0 : RV32M_INT_MIN;
        end
        accept = (state_q == SEQ_IDLE) && start && !flush;
`ifdef RV32M_SEQ_RESULT_CACHE_EN
        // Signed DIV/REM have funct3[0]=0; the tag keeps signed and unsigned apart.
        cache_hit = cache_v_q && (tag_a_q == rs1_data) && (tag_b_q == rs2_data) &&
                    (tag_s_q == ~op[0]);
`else
        cache_hit = 1'b0;
`endif
    end

    // Next-state and datapath register updates for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        mag_a_d      = mag_a_q;
        mag_b_d      = mag_b_q;
        prod_d       = prod_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        pend_d       = pend_q;
        result_d     = result_q;
        mul_start_d  = 1'b0;
        div_start_d  = 1'b0;
        unit_flush_d = 1'b0;
`ifdef RV32M_SEQ_RESULT_CACHE_EN
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        tag_a_d   = tag_a_q;
        tag_b_d   = tag_b_q;
        tag_s_d   = tag_s_q;
        cache_v_d = cache_v_q;
        if (flush && (state_q != SEQ_IDLE)) begin
            cache_v_d = 1'b0;
        end
`endif

        case (state_q)
            SEQ_IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    // Negating 0x80000000 yields 0x80000000, the correct unsigned magnitude.
                    mag_a_d = sa_in ? -rs1_data : rs1_data;
                    mag_b_d = sb_in ? -rs2_data : rs2_data;
`ifdef RV32M_SEQ_RESULT_CACHE_EN
                    rs1_d = rs1_data;
                    rs2_d = rs2_data;
                    if (special) begin
                        cache_v_d = 1'b0;
                    end
`endif
                    if (special) begin
                        pend_d  = special_res;
                        state_d = SEQ_DONE;
                    end else if (!is_div(op)) begin
                        mul_start_d = 1'b1;
                        state_d     = SEQ_WAIT_MUL;
                    end else if (cache_hit) begin
                        state_d = SEQ_FIXUP;
                    end else begin
                        div_start_d = 1'b1;
                        state_d     = SEQ_WAIT_DIV;
                    end
                end
            end
            SEQ_WAIT_MUL: begin
                if (flush) begin
                    unit_flush_d = 1'b1;
                    state_d      = SEQ_IDLE;
                end else if (mul_done) begin
                    prod_d  = mul_product;
                    state_d = SEQ_FIXUP;
                end
            end
            SEQ_WAIT_DIV: begin
                if (flush) begin
                    unit_flush_d = 1'b1;
                    state_d      = SEQ_IDLE;
                end else if (div_done) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    state_d = SEQ_FIXUP;
`ifdef RV32M_SEQ_RESULT_CACHE_EN
                    tag_a_d   = rs1_q;
                    tag_b_d   = rs2_q;
                    tag_s_d   = ~op_q[0];
                    cache_v_d = 1'b1;
`endif
                end
            end
            SEQ_FIXUP: begin
                if (flush) begin
                    state_d = SEQ_IDLE;
                end else begin
                    pend_d  = fix_result;
                    state_d = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                // The visible result only commits if the done pulse is not flushed.
                if (!flush) begin
                    result_d = pend_q;
                end
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= SEQ_IDLE;
            op_q         <= OP_MUL;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            mag_a_q      <= '0;
            mag_b_q      <= '0;
            prod_q       <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            pend_q       <= '0;
            result_q     <= '0;
            mul_start_q  <= 1'b0;
            div_start_q  <= 1'b0;
            unit_flush_q <= 1'b0;
`ifdef RV32M_SEQ_RESULT_CACHE_EN
            rs1_q     <= '0;
            rs2_q     <= '0;
            tag_a_q   <= '0;
            tag_b_q   <= '0;
            tag_s_q   <= 1'b0;
            cache_v_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            mag_a_q      <= mag_a_d;
            mag_b_q      <= mag_b_d;
            prod_q       <= prod_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            pend_q       <= pend_d;
            result_q     <= result_d;
            mul_start_q  <= mul_start_d;
            div_start_q  <= div_start_d;
            unit_flush_q <= unit_flush_d;
`ifdef RV32M_SEQ_RESULT_CACHE_EN
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            tag_a_q   <= tag_a_d;
            tag_b_q   <= tag_b_d;
            tag_s_q   <= tag_s_d;
            cache_v_q <= cache_v_d;
`endif
        end
    end

    // Outputs: done is withdrawn by a same-cycle flush, and result only
    // shows the pending value while done is actually asserted.
    always_comb begin
        busy         = (state_q != SEQ_IDLE);
        done         = (state_q == SEQ_DONE) && !flush;
        result       = done ? pend_q : result_q;
        mul_start    = mul_start_q;
        div_start    = div_start_q;
        unit_flush   = unit_flush_q;
        mul_a        = mag_a_q;
        mul_b        = mag_b_q;
        div_dividend = mag_a_q;
        div_divisor  = mag_b_q;
    end

endmodule

// File: tb/tb_rv32m_sequencer.sv
// Self-checking bench for rv32m_sequencer: stub mul/div units with random
// latency, directed corner cases and a randomized op stream compared against
// an arithmetic reference model. Honours RV32M_SEQ_RESULT_CACHE_EN.
module tb_rv32m_sequencer;

`ifdef RV32M_SEQ_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [2:0] C_MUL = 3'd0, C_MULH = 3'd1, C_MULHSU = 3'd2, C_MULHU = 3'd3;
    localparam logic [2:0] C_DIV = 3'd4, C_DIVU = 3'd5, C_REM = 3'd6, C_REMU = 3'd7;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic        mul_done = 1'b0;
    logic [63:0] mul_product = '0;
    logic        div_start;
    logic [31:0] div_dividend, div_divisor;
    logic        div_done = 1'b0;
    logic [31:0] div_quotient = '0, div_remainder = '0;
    logic        unit_flush;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rv32m_sequencer #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .busy(busy), .done(done), .result(result),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .unit_flush(unit_flush)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Stub units: answer (lat+1) cycles after their start pulse; they ignore unit_flush.
    int mul_lat = 3, div_lat = 3;
    int mcnt = 0, dcnt = 0;
    logic [31:0] ma_l = '0, mb_l = '0, da_l = '0, db_l = '0;

    always @(posedge CLK) begin
        mul_done <= 1'b0;
        div_done <= 1'b0;
        if (RST) begin
            mcnt <= 0;
            dcnt <= 0;
        end else begin
            if (mul_start) begin
                mcnt <= mul_lat; ma_l <= mul_a; mb_l <= mul_b;
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    mul_done    <= 1'b1;
                    mul_product <= {32'b0, ma_l} * {32'b0, mb_l};
                end
            end
            if (div_start) begin
                dcnt <= div_lat; da_l <= div_dividend; db_l <= div_divisor;
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    div_done      <= 1'b1;
                    div_quotient  <= (db_l == 0) ? 32'hFFFFFFFF : da_l / db_l;
                    div_remainder <= (db_l == 0) ? da_l : da_l % db_l;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with plain integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa64, sb64;
        longint unsigned ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa64 = $signed(a);
        sb64 = $signed(b);
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        ia   = a;
        ib   = b;
        case (o)
            C_MUL:    begin p = ua * ub; return p[31:0]; end
            C_MULH:   begin p = sa64 * sb64; return p[63:32]; end
            C_MULHSU: begin p = sa64 * longint'(ub); return p[63:32]; end
            C_MULHU:  begin p = ua * ub; return p[63:32]; end
            C_DIV, C_REM: begin
                if (b == 0) return (o == C_DIV) ? 32'hFFFFFFFF : a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return (o == C_DIV) ? a : 32'h0;
                return (o == C_DIV) ? ia / ib : ia % ib;
            end
            default: begin
                if (b == 0) return (o == C_DIVU) ? 32'hFFFFFFFF : a;
                return (o == C_DIVU) ? a / b : a % b;
            end
        endcase
    endfunction

    // Reference view of the divider result cache (only ever set when CACHE).
    bit          cache_v = 1'b0;
    logic [31:0] cache_a = '0, cache_b = '0;
    bit          cache_s = 1'b0;

    logic [31:0] last_res, last_ma, last_mb;

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int t, dcyc, udone, nm, nd;
        bit spec, hit, found;
        logic [31:0] got;
        spec = o[2] && (b == 0 || ((o == C_DIV || o == C_REM) &&
                        a == 32'h80000000 && b == 32'hFFFFFFFF));
        hit  = CACHE && cache_v && o[2] && !spec && cache_a == a && cache_b == b &&
               cache_s == !o[0];
        @(negedge CLK);
        start = 1'b1; op = o; rs1_data = a; rs2_data = b; t = cyc;
        @(negedge CLK);
        start = 1'b0;
        nm = 0; nd = 0; found = 1'b0; udone = -100; dcyc = -1; got = 'x;
        for (int k = 0; k < 60 && !found; k++) begin
            if (mul_start) begin nm++; last_ma = mul_a; last_mb = mul_b; end
            if (div_start) nd++;
            if (o[2] ? div_done : mul_done) udone = cyc;
            if (done) begin
                found = 1'b1; dcyc = cyc; got = result;
            end else begin
                @(negedge CLK);
            end
        end
        last_res = got;
        chk({tag, "_done"}, found, 1);
        chk({tag, "_res"}, got, ref_res(o, a, b));
        chk({tag, "_lat"}, dcyc, spec ? t + 1 : (hit ? t + 2 : udone + 2));
        chk({tag, "_starts"}, {nm[15:0], nd[15:0]},
            {((!o[2] && !spec) ? 16'd1 : 16'd0), ((o[2] && !spec && !hit) ? 16'd1 : 16'd0)});
        if (o[2]) begin
            if (spec) cache_v = 1'b0;
            else if (!hit) begin cache_v = CACHE; cache_a = a; cache_b = b; cache_s = !o[0]; end
        end
        @(negedge CLK);
        chk({tag, "_pulse"}, {done, busy}, 2'b00);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [227:0] outs();
        return {busy, done, result, mul_start, mul_a, mul_b, div_start,
                div_dividend, div_divisor, unit_flush};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic [2:0] ro;
        repeat (3) @(negedge CLK);
        chk("reset_outs", outs(), '0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_outs", outs(), '0);

        // MULH -2 * 3: magnitudes 2 and 3, result -1 in the high word.
        mul_lat = 3;
        run_op(C_MULH, 32'hFFFFFFFE, 32'h3, "mulh");
        chk("mulh_mags", {last_ma, last_mb}, {32'd2, 32'd3});
        chk("mulh_const", last_res, 32'hFFFFFFFF);

        run_op(C_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        chk("div_ovf_const", last_res, 32'h80000000);
        run_op(C_REM, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
        chk("rem_ovf_const", last_res, 32'h0);
        run_op(C_REMU, 32'h1234, 32'h0, "remu_z");
        chk("remu_z_const", last_res, 32'h1234);
        run_op(C_DIVU, 32'h7, 32'h0, "divu_z");
        chk("divu_z_const", last_res, 32'hFFFFFFFF);

        div_lat = 4;
        run_op(C_DIV, 32'hFFFFFFF9, 32'h2, "div_m7");
        chk("div_m7_const", last_res, 32'hFFFFFFFD);
        run_op(C_REM, 32'hFFFFFFF9, 32'h2, "rem_m7");
        chk("rem_m7_const", last_res, 32'hFFFFFFFF);

        // Flush during WAIT_DIV; the stub still answers late and must be ignored.
        div_lat = 6;
        @(negedge CLK);
        start = 1'b1; op = C_DIV; rs1_data = 32'd100; rs2_data = 32'd9;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("flush_uf_busy", {unit_flush, busy, done}, 3'b100);
        cache_v = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (done || busy || unit_flush) seen++;
        end
        chk("flush_quiet", seen, 0);
        mul_lat = 2;
        run_op(C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
        chk("mulhu_const", last_res, 32'hFFFFFFFE);

        // start together with flush in IDLE is not accepted.
        @(negedge CLK);
        start = 1'b1; flush = 1'b1; op = C_DIVU; rs1_data = 32'd5; rs2_data = 32'd0;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_start", {busy, done}, 2'b00);

        // start while busy is ignored: only the first op completes.
        mul_lat = 4;
        @(negedge CLK);
        start = 1'b1; op = C_MUL; rs1_data = 32'd3; rs2_data = 32'd5;
        @(negedge CLK);
        op = C_DIVU; rs1_data = 32'd100; rs2_data = 32'd0;
        @(negedge CLK);
        start = 1'b0;
        seen = 0; ra = 'x;
        repeat (15) begin
            if (done) begin seen++; ra = result; end
            @(negedge CLK);
        end
        chk("busy_start_count", seen, 1);
        chk("busy_start_res", ra, 32'd15);

        // Reset while waiting on the multiplier.
        mul_lat = 5;
        @(negedge CLK);
        start = 1'b1; op = C_MUL; rs1_data = 32'd6; rs2_data = 32'd7;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_wait_outs", outs(), '0);
        RST = 1'b0;
        cache_v = 1'b0;
        @(negedge CLK);

        // Randomized stream; operands sometimes repeat to exercise the cache.
        ra = 32'd10; rb = 32'd3;
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                ra = pick(); rb = pick();
            end
            mul_lat = $urandom_range(1, 5);
            div_lat = $urandom_range(1, 5);
            run_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
